// File: rtl/seq_divider_pkg.sv
// div_pkg: shared constants and FSM encoding for the sequential divider.
package div_pkg;
   localparam int DIV_WIDTH = 32;
   localparam logic [31:0] DIV_Q_DZ = 32'hFFFF_FFFF;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FIX = 2'd2} state_e;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle between the core and the divider.
interface seq_divider_if #(parameter int WIDTH = 32);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             busy;
   logic             done;
   logic             div_zero;
   modport master (output start, is_signed, dividend, divisor, input q, r, busy, done, div_zero);
   modport slave (input start, is_signed, dividend, divisor, output q, r, busy, done, div_zero);
endinterface

// File: rtl/seq_divider_sign_fix.sv
// div_sign_fix: applies result signs to the magnitude quotient/remainder, with divide-by-zero override.
module div_sign_fix
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] dividend,
   input  logic             sign_q,
   input  logic             sign_r,
   input  logic             dz,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);
   always_comb begin
      q = dz ? WIDTH'(DIV_Q_DZ) : sign_q ? -quo : quo;
      r = dz ? dividend : sign_r ? -rem : rem;
   end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider for signed and unsigned operands.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 5
) (
   input logic         clk,
   input logic         rst,
   seq_divider_if.slave d
);
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
   logic               sq_q, sq_d, sr_q, sr_d, dz_q, dz_d;
   logic [WIDTH-1:0]   q_q, q_d, r_q, r_d;
   logic               done_q, done_d, div_zero_q, div_zero_d;
   logic [WIDTH:0]     shifted;
   logic [WIDTH-1:0]   trial, fix_q, fix_r;
   logic               no_borrow, neg_a, neg_b;

   div_sign_fix #(.WIDTH(WIDTH)) u_fix (
      .quo(quo_q), .rem(rem_q), .dividend(dvd_q),
      .sign_q(sq_q), .sign_r(sr_q), .dz(dz_q),
      .q(fix_q), .r(fix_r)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         dvd_q      <= '0;
         sq_q       <= 1'b0;
         sr_q       <= 1'b0;
         dz_q       <= 1'b0;
         q_q        <= '0;
         r_q        <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         dvd_q      <= dvd_d;
         sq_q       <= sq_d;
         sr_q       <= sr_d;
         dz_q       <= dz_d;
         q_q        <= q_d;
         r_q        <= r_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvs_d      = dvs_q;
      dvd_d      = dvd_q;
      sq_d       = sq_q;
      sr_d       = sr_q;
      dz_d       = dz_q;
      q_d        = q_q;
      r_d        = r_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;
      neg_a      = d.is_signed & d.dividend[WIDTH-1];
      neg_b      = d.is_signed & d.divisor[WIDTH-1];
      // shifted can reach 2*divisor-1, so compare at WIDTH+1 bits; the difference always fits WIDTH
      shifted    = {rem_q, quo_q[WIDTH-1]};
      no_borrow  = shifted >= {1'b0, dvs_q};
      trial      = shifted[WIDTH-1:0] - dvs_q;
      case (state_q)
         S_IDLE: begin
            if (d.start) begin
               state_d = S_ITER;
               cnt_d   = '0;
               rem_d   = '0;
               quo_d   = neg_a ? -d.dividend : d.dividend;
               dvs_d   = neg_b ? -d.divisor : d.divisor;
               dvd_d   = d.dividend;
               sq_d    = neg_a ^ neg_b;
               sr_d    = neg_a;
               dz_d    = d.divisor == '0;
            end
         end
         S_ITER: begin
            rem_d   = no_borrow ? trial : shifted[WIDTH-1:0];
            quo_d   = {quo_q[WIDTH-2:0], no_borrow};
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CNT_W'(WIDTH - 1) ? S_FIX : S_ITER;
         end
         S_FIX: begin
            q_d        = fix_q;
            r_d        = fix_r;
            div_zero_d = dz_q;
            done_d     = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign d.q        = q_q;
   assign d.r        = r_q;
   assign d.busy     = state_q != S_IDLE;
   assign d.done     = done_q;
   assign d.div_zero = div_zero_q;
endmodule
